// File: rtl/sk_key_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sk_key_pkg
// Shared definitions for the sk key-load controller:
//   - controller state encoding
//   - default key / word widths
//   - nwords(): number of load-stream words making up one key
//   - params_ok(): parameter legality test used at elaboration time
// ----------------------------------------------------------------------------
package sk_key_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        ERR    = 3'd4
    } sk_state_e;

    localparam int SK_KEY_W_DEFAULT  = 128;
    localparam int SK_WORD_W_DEFAULT = 32;

    function automatic int nwords(input int key_w, input int word_w);
        return key_w / word_w;
    endfunction

    // Key must split into a whole number of words, and the core must see at
    // least one cycle of reset after the last word lands.
    function automatic bit params_ok(input int key_w, input int word_w,
                                     input int settle_cyc);
        return (word_w > 0) && (key_w >= word_w) && ((key_w % word_w) == 0)
               && (settle_cyc >= 1);
    endfunction

endpackage

// File: rtl/sk_key_load_ctrl_bank.sv
// ----------------------------------------------------------------------------
// sk_key_bank
// Word-addressed key register. Holds the assembled KEY_W-bit key that drives
// the locked core's sk input.
// Ports:
//   blif_clk_net    clock
//   blif_reset_net  asynchronous active-low reset (key -> 0)
//   clr             synchronous zeroise, wins over a write
//   we              write enable for word idx
//   idx             word index; word 0 is the least significant word
//   wdata           word data
//   key             registered key
// ----------------------------------------------------------------------------
module sk_key_bank #(
    parameter int KEY_W  = 128,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [KEY_W-1:0]  key
);

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            key <= '0;
        end else if (clr) begin
            key <= '0;
        end else if (we) begin
            key[int'(idx) * WORD_W +: WORD_W] <= wdata;
        end
    end

endmodule

// File: rtl/sk_key_load_ctrl.sv
// ----------------------------------------------------------------------------
// sk_key_load_ctrl
// Sequences loading of the locking key sk into a key-locked core. Key words
// arrive on a valid/ready stream, are assembled into a registered key bus, and
// the core is held in reset until the full key has been applied and a settle
// interval of SETTLE_CYC cycles has elapsed.
//
// Optional feature macro: SK_KEY_PARITY_CHECK_EN
//   Adds key_par_i (even parity of key_word_i). A parity mismatch on a
//   transfer zeroises the key and parks the controller in ERR (err_o=1) until
//   clear_i or reset. Without the macro the port is absent and err_o is 0.
//
// Ports:
//   blif_clk_net    clock
//   blif_reset_net  asynchronous active-low reset
//   load_start_i    pulse: start a key load (from IDLE or RUN)
//   clear_i         pulse: zeroise key, return to IDLE (highest priority)
//   key_word_i      key word data
//   key_valid_i     key word valid
//   key_par_i       even parity of key_word_i (parity build only)
//   key_ready_o     controller accepts a word (LOAD)
//   sk              applied key
//   core_reset_o    active-high reset to the locked core
//   key_loaded_o    key applied, core running (RUN)
//   busy_o          LOAD or SETTLE
//   err_o           sticky parity error (ERR)
// All outputs are registers or decodes of the state register only.
// ----------------------------------------------------------------------------
module sk_key_load_ctrl
    import sk_key_pkg::*;
#(
    parameter int KEY_W      = SK_KEY_W_DEFAULT,
    parameter int WORD_W     = SK_WORD_W_DEFAULT,
    parameter int SETTLE_CYC = 4
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              load_start_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] key_word_i,
    input  logic              key_valid_i,
`ifdef SK_KEY_PARITY_CHECK_EN
    input  logic              key_par_i,
`endif
    output logic              key_ready_o,
    output logic [KEY_W-1:0]  sk,
    output logic              core_reset_o,
    output logic              key_loaded_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int NWORDS = nwords(KEY_W, WORD_W);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);

    if (!params_ok(KEY_W, WORD_W, SETTLE_CYC)) begin : g_param_check
        $error("sk_key_load_ctrl: KEY_W must be a multiple of WORD_W and SETTLE_CYC >= 1");
    end

    sk_state_e        state_q;
    sk_state_e        state_d;
    logic [IDX_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] settle_cnt_q;
    logic             xfer;
    logic             par_bad;
    logic             bank_clr;
    logic             bank_we;

    assign xfer = key_valid_i && (state_q == LOAD);

`ifdef SK_KEY_PARITY_CHECK_EN
    assign par_bad = (key_par_i != ^key_word_i);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and key-bank control. clear_i pre-empts everything,
    // including a word transfer on the same edge (that word is dropped).
    always_comb begin
        state_d  = state_q;
        bank_clr = 1'b0;
        bank_we  = 1'b0;
        if (clear_i) begin
            state_d  = IDLE;
            bank_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        state_d  = LOAD;
                        bank_clr = 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (par_bad) begin
                            state_d  = ERR;
                            bank_clr = 1'b1;
                        end else begin
                            bank_we = 1'b1;
                            if (word_cnt_q == LAST_IDX) begin
                                state_d = SETTLE;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Reload: core goes back into reset and key is wiped on
                    // the same edge, so no partial key ever reaches a running core.
                    if (load_start_i) begin
                        state_d  = LOAD;
                        bank_clr = 1'b1;
                    end
                end
                ERR: begin
                    bank_clr = 1'b1;
                end
                default: begin
                    state_d  = IDLE;
                    bank_clr = 1'b1;
                end
            endcase
        end
    end

    // Word counter is parked at 0 outside LOAD, so every entry into LOAD
    // starts at word 0. Settle counter runs only while staying in SETTLE;
    // reaching SETTLE_LAST gives the SETTLE_CYC+1 edge release latency.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            if (state_q != LOAD) begin
                word_cnt_q <= '0;
            end else if (bank_we) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if ((state_q == SETTLE) && (state_d == SETTLE)) begin
                settle_cnt_q <= settle_cnt_q + 1'b1;
            end else begin
                settle_cnt_q <= '0;
            end
        end
    end

    sk_key_bank #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .clr            (bank_clr),
        .we             (bank_we),
        .idx            (word_cnt_q),
        .wdata          (key_word_i),
        .key            (sk)
    );

    assign key_ready_o  = (state_q == LOAD);
    assign busy_o       = (state_q == LOAD) || (state_q == SETTLE);
    assign core_reset_o = (state_q != RUN);
    assign key_loaded_o = (state_q == RUN);

`ifdef SK_KEY_PARITY_CHECK_EN
    assign err_o = (state_q == ERR);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sk_key_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sk_key_load_ctrl
// Self-checking bench for sk_key_load_ctrl (KEY_W=128, WORD_W=32,
// SETTLE_CYC=4). Expected keys are queued when a load is driven and popped
// when the core is released. Parity scenario built with
// SK_KEY_PARITY_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_sk_key_load_ctrl;

    localparam int KEY_W      = 128;
    localparam int WORD_W     = 32;
    localparam int SETTLE_CYC = 4;
    localparam int NW         = KEY_W / WORD_W;

    localparam logic [127:0] KEY1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] KEY2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] KEYB = 128'h11112222_33334444_55556666_77778888;

    logic              blif_clk_net   = 1'b0;
    logic              blif_reset_net = 1'b0;
    logic              load_start_i   = 1'b0;
    logic              clear_i        = 1'b0;
    logic [WORD_W-1:0] key_word_i     = '0;
    logic              key_valid_i    = 1'b0;
`ifdef SK_KEY_PARITY_CHECK_EN
    logic              key_par_i      = 1'b0;
`endif
    logic              key_ready_o;
    logic [KEY_W-1:0]  sk;
    logic              core_reset_o;
    logic              key_loaded_o;
    logic              busy_o;
    logic              err_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [KEY_W-1:0] sb_q[$];

    sk_key_load_ctrl #(
        .KEY_W      (KEY_W),
        .WORD_W     (WORD_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .load_start_i   (load_start_i),
        .clear_i        (clear_i),
        .key_word_i     (key_word_i),
        .key_valid_i    (key_valid_i),
`ifdef SK_KEY_PARITY_CHECK_EN
        .key_par_i      (key_par_i),
`endif
        .key_ready_o    (key_ready_o),
        .sk             (sk),
        .core_reset_o   (core_reset_o),
        .key_loaded_o   (key_loaded_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 blif_clk_net = ~blif_clk_net;
    always @(posedge blif_clk_net) cyc <= cyc + 1;

    task automatic tick();
        @(posedge blif_clk_net);
        #1;
    endtask

    // Present one word and hold it until accepted; returns the accepting edge.
    task automatic send_word(input logic [WORD_W-1:0] w, output int acc_cyc);
        key_word_i  = w;
        key_valid_i = 1'b1;
`ifdef SK_KEY_PARITY_CHECK_EN
        key_par_i   = ^w;
`endif
        for (int i = 0; i < 20 && key_ready_o !== 1'b1; i++) tick();
        total++;
        if (key_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: key_ready_o=%b want 1", key_ready_o);
        end
        tick();
        acc_cyc     = cyc;
        key_valid_i = 1'b0;
    endtask

    // Wait (bounded) for core release, then pop and compare the scoreboard.
    task automatic wait_run(input int last_edge);
        logic [KEY_W-1:0] exp_key;
        exp_key = '0;
        for (int i = 0; i < 20 && core_reset_o !== 1'b0; i++) begin
            tick();
            total++;
            if (core_reset_o !== 1'b0 && key_loaded_o !== 1'b0) begin
                bad++;
                $display("FAIL settle_loaded: key_loaded_o=%b want 0", key_loaded_o);
            end
        end
        total++;
        if (core_reset_o !== 1'b0 || key_loaded_o !== 1'b1) begin
            bad++;
            $display("FAIL run_entry: core_reset_o=%b key_loaded_o=%b want 0/1",
                     core_reset_o, key_loaded_o);
        end
        total++;
        if (cyc - last_edge != SETTLE_CYC + 1) begin
            bad++;
            $display("FAIL release_latency: got %0d cycles want %0d",
                     cyc - last_edge, SETTLE_CYC + 1);
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            exp_key = sb_q.pop_front();
            if (sk !== exp_key) begin
                bad++;
                $display("FAIL key_value: sk=%h want %h", sk, exp_key);
            end
        end
    endtask

    // Full load of key k; gap_len idle cycles between words 1 and 2.
    task automatic load_key(input logic [KEY_W-1:0] k, input int gap_len);
        int acc;
        acc = 0;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        total++;
        if (core_reset_o !== 1'b1 || sk !== '0 || key_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL load_entry: core_reset_o=%b sk=%h ready=%b busy=%b want 1/0/1/1",
                     core_reset_o, sk, key_ready_o, busy_o);
        end
        for (int w = 0; w < NW; w++) begin
            send_word(k[w*WORD_W +: WORD_W], acc);
            if (w == 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    total++;
                    if (core_reset_o !== 1'b1 || key_ready_o !== 1'b1) begin
                        bad++;
                        $display("FAIL gap_hold: core_reset_o=%b ready=%b want 1/1",
                                 core_reset_o, key_ready_o);
                    end
                end
            end
        end
        sb_q.push_back(k);
        total++;
        if (key_ready_o !== 1'b0 || busy_o !== 1'b1 || core_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL settle_entry: ready=%b busy=%b core_reset_o=%b want 0/1/1",
                     key_ready_o, busy_o, core_reset_o);
        end
        wait_run(acc);
    endtask

    task automatic test_reset();
        blif_reset_net = 1'b0;
        tick();
        tick();
        total++;
        if (sk !== '0 || key_ready_o !== 1'b0 || core_reset_o !== 1'b1 ||
            key_loaded_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: sk=%h rdy=%b crst=%b ld=%b busy=%b err=%b want 0/0/1/0/0/0",
                     sk, key_ready_o, core_reset_o, key_loaded_o, busy_o, err_o);
        end
        blif_reset_net = 1'b1;
        tick();
        total++;
        if (core_reset_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: crst=%b busy=%b want 1/0", core_reset_o, busy_o);
        end
    endtask

    task automatic test_full_load();
        load_key(KEY1, 0);
    endtask

    task automatic test_gap_load();
        load_key(KEY1, 10);
    endtask

    task automatic test_clear_mid();
        int acc;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        send_word(KEY1[31:0], acc);
        send_word(KEY1[63:32], acc);
        key_word_i  = KEY1[95:64];
        key_valid_i = 1'b1;
        clear_i     = 1'b1;
        tick();
        clear_i     = 1'b0;
        key_valid_i = 1'b0;
        total++;
        if (sk !== '0 || core_reset_o !== 1'b1 || busy_o !== 1'b0 || key_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_mid: sk=%h crst=%b busy=%b rdy=%b want 0/1/0/0",
                     sk, core_reset_o, busy_o, key_ready_o);
        end
        tick();
        load_key(KEY2, 0);
    endtask

    task automatic test_reload();
        total++;
        if (key_loaded_o !== 1'b1 || core_reset_o !== 1'b0 || sk !== KEY2) begin
            bad++;
            $display("FAIL reload_pre: ld=%b crst=%b sk=%h want 1/0/%h",
                     key_loaded_o, core_reset_o, sk, KEY2);
        end
        load_key(KEYB, 0);
    endtask

    task automatic test_reset_mid_settle();
        int  acc;
        logic seen;
        seen = 1'b0;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        for (int w = 0; w < NW; w++) send_word(KEYB[w*WORD_W +: WORD_W], acc);
        tick();
        tick();
        #2;
        blif_reset_net = 1'b0;
        #1;
        total++;
        if (sk !== '0 || key_ready_o !== 1'b0 || core_reset_o !== 1'b1 ||
            key_loaded_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: sk=%h rdy=%b crst=%b ld=%b busy=%b err=%b want 0/0/1/0/0/0",
                     sk, key_ready_o, core_reset_o, key_loaded_o, busy_o, err_o);
        end
        tick();
        blif_reset_net = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (key_loaded_o !== 1'b0 || core_reset_o !== 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL no_release_after_reset: seen=%b want 0", seen);
        end
    endtask

`ifdef SK_KEY_PARITY_CHECK_EN
    task automatic test_parity();
        int acc;
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        send_word(KEY1[31:0], acc);
        key_word_i  = KEY1[63:32];
        key_par_i   = ~(^KEY1[63:32]);
        key_valid_i = 1'b1;
        tick();
        key_valid_i = 1'b0;
        total++;
        if (err_o !== 1'b1 || sk !== '0 || key_ready_o !== 1'b0 || core_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL parity_err: err=%b sk=%h rdy=%b crst=%b want 1/0/0/1",
                     err_o, sk, key_ready_o, core_reset_o);
        end
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
        total++;
        if (err_o !== 1'b1 || key_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL parity_sticky: err=%b rdy=%b want 1/0", err_o, key_ready_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        total++;
        if (err_o !== 1'b0 || busy_o !== 1'b0 || core_reset_o !== 1'b1 || sk !== '0) begin
            bad++;
            $display("FAIL parity_clear: err=%b busy=%b crst=%b sk=%h want 0/0/1/0",
                     err_o, busy_o, core_reset_o, sk);
        end
        load_key(KEY2, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gap_load();
        test_clear_mid();
        test_reload();
        test_reset_mid_settle();
`ifdef SK_KEY_PARITY_CHECK_EN
        test_parity();
`endif
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
